// File: rtl/tracker_ctrl.sv
// Tracker controller: round-robin write arbitration from NREQ requesters into an
// address tracker, plus a windowed read handshake. All outputs are registered.
module tracker_ctrl #(
  parameter int ADDR_W  = 20,
  parameter int NREQ    = 4,
  parameter int DEPTH   = 512,
  parameter int WIN     = 8,
  parameter int RD_STEP = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  output logic [NREQ-1:0]          gnt,
  input  logic                     cons_req,
  input  logic                     cons_ack,
  output logic                     win_valid,
  output logic [ADDR_W-1:0]        trk_din,
  output logic                     trk_write,
  output logic                     trk_read,
  output logic [9:0]               count,
  output logic                     full,
  output logic                     empty
);

  localparam int CW   = 10;
  localparam int RR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, WR, RD, HOLD} state_t;

  state_t            state_reg, state_next;
  logic [CW-1:0]     count_reg, count_next;
  logic [RR_W-1:0]   rr_reg, rr_next;
  logic [NREQ-1:0]   gnt_reg, gnt_next;
  logic [ADDR_W-1:0] din_reg, din_next;
  logic              wr_reg, wr_next;
  logic              rd_reg, rd_next;
  logic              win_reg, win_next;
  logic              full_reg, empty_reg;

  logic [ADDR_W-1:0] addr_slice [NREQ];
  logic              sel_found;
  logic [RR_W-1:0]   sel_idx;
  logic              rd_elig, wr_elig;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
    assign addr_slice[gi] = req_addr[gi*ADDR_W +: ADDR_W];
  end

  // Walk offsets from the far end so the requester closest to rr wins.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[(int'(rr_reg) + i) % NREQ]) begin
        sel_found = 1'b1;
        sel_idx   = RR_W'((int'(rr_reg) + i) % NREQ);
      end
    end
  end

  assign rd_elig = cons_req && (count_reg >= CW'(WIN));
  assign wr_elig = sel_found && (count_reg < CW'(DEPTH));

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    rr_next    = rr_reg;
    gnt_next   = '0;
    din_next   = din_reg;
    wr_next    = 1'b0;
    rd_next    = 1'b0;
    win_next   = 1'b0;
    case (state_reg)
      IDLE, WR: begin
        if (rd_elig) begin
          state_next = RD;
          rd_next    = 1'b1;
          count_next = count_reg - CW'(RD_STEP);
        end else if (wr_elig) begin
          state_next = WR;
          wr_next    = 1'b1;
          gnt_next   = NREQ'(1) << sel_idx;
          din_next   = addr_slice[sel_idx];
          count_next = count_reg + 1'b1;
          rr_next    = RR_W'((int'(sel_idx) + 1) % NREQ);
        end else begin
          state_next = IDLE;
        end
      end
      RD: begin
        state_next = HOLD;
        win_next   = 1'b1;
      end
      HOLD: begin
        if (cons_ack) state_next = IDLE;
        else          win_next   = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  // Flags are computed from count_next so they change on the same edge as count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      count_reg <= '0;
      rr_reg    <= '0;
      gnt_reg   <= '0;
      din_reg   <= '0;
      wr_reg    <= 1'b0;
      rd_reg    <= 1'b0;
      win_reg   <= 1'b0;
      full_reg  <= 1'b0;
      empty_reg <= 1'b1;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      rr_reg    <= rr_next;
      gnt_reg   <= gnt_next;
      din_reg   <= din_next;
      wr_reg    <= wr_next;
      rd_reg    <= rd_next;
      win_reg   <= win_next;
      full_reg  <= (count_next == CW'(DEPTH));
      empty_reg <= (count_next == '0);
    end
  end

  assign gnt       = gnt_reg;
  assign trk_din   = din_reg;
  assign trk_write = wr_reg;
  assign trk_read  = rd_reg;
  assign win_valid = win_reg;
  assign count     = count_reg;
  assign full      = full_reg;
  assign empty     = empty_reg;

endmodule

// File: tb/tb_tracker_ctrl.sv
// Bench for tracker_ctrl: vector table, directed corner sequences and random
// traffic, all checked against a behavioural model of the tracker rules.
module tb_tracker_ctrl;

  localparam int ADDR_W  = 20;
  localparam int NREQ    = 4;
  localparam int DEPTH   = 512;
  localparam int WIN     = 8;
  localparam int RD_STEP = 2;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NREQ-1:0]        req;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic                   cons_req, cons_ack;
  logic [NREQ-1:0]        gnt;
  logic                   win_valid, trk_write, trk_read, full, empty;
  logic [ADDR_W-1:0]      trk_din;
  logic [9:0]             count;

  tracker_ctrl #(
    .ADDR_W(ADDR_W), .NREQ(NREQ), .DEPTH(DEPTH), .WIN(WIN), .RD_STEP(RD_STEP)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .gnt(gnt),
    .cons_req(cons_req), .cons_ack(cons_ack), .win_valid(win_valid),
    .trk_din(trk_din), .trk_write(trk_write), .trk_read(trk_read),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: occupancy, rr pointer and read-window phase
  // (0 = free to decide, 1 = read strobe issued, 2 = window open).
  int                m_count, m_rr, m_phase;
  logic [NREQ-1:0]   m_gnt;
  logic              m_wr, m_rd, m_win;
  logic [ADDR_W-1:0] m_din;

  function automatic logic [ADDR_W-1:0] addr_of(int k);
    return req_addr[k*ADDR_W +: ADDR_W];
  endfunction

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
    end
  endtask

  task automatic model_step();
    m_gnt = '0;
    m_wr  = 1'b0;
    m_rd  = 1'b0;
    if (rst) begin
      m_count = 0; m_rr = 0; m_phase = 0; m_din = '0; m_win = 1'b0;
    end else if (m_phase == 1) begin
      m_phase = 2; m_win = 1'b1;
    end else if (m_phase == 2) begin
      if (cons_ack) begin m_phase = 0; m_win = 1'b0; end
      else m_win = 1'b1;
    end else begin
      m_win = 1'b0;
      if (cons_req && m_count >= WIN) begin
        m_phase = 1; m_rd = 1'b1; m_count -= RD_STEP;
      end else if (req != 0 && m_count < DEPTH) begin
        for (int i = 0; i < NREQ; i++) begin
          int k;
          k = (m_rr + i) % NREQ;
          if (req[k]) begin
            m_gnt[k] = 1'b1; m_wr = 1'b1; m_din = addr_of(k);
            m_count++; m_rr = (k + 1) % NREQ;
            break;
          end
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    cyc++;
    #1;
    check("gnt", gnt, m_gnt);
    check("trk_write", trk_write, m_wr);
    check("trk_read", trk_read, m_rd);
    check("win_valid", win_valid, m_win);
    check("trk_din", trk_din, m_din);
    check("count", count, m_count);
    check("full", full, m_count == DEPTH);
    check("empty", empty, m_count == 0);
    check("rd_wr_excl", trk_write & trk_read, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; cons_req = 1'b0; cons_ack = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  typedef struct {
    logic              rst;
    logic [NREQ-1:0]   req;
    logic              cr, ca;
    logic [NREQ-1:0]   gnt;
    logic              wr, rd, win;
    int                cnt;
    logic [ADDR_W-1:0] din;
  } vec_t;

  vec_t vt[8];

  initial begin
    rst = 1'b1; req = '0; cons_req = 1'b0; cons_ack = 1'b0;
    for (int k = 0; k < NREQ; k++) req_addr[k*ADDR_W +: ADDR_W] = ADDR_W'(32'h100 + k);

    // Each row is one clock from reset; addresses are 0x100+k.
    vt[0] = '{1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 0, 20'h000};
    vt[1] = '{1'b0, 4'b0001, 1'b0, 1'b0, 4'b0001, 1'b1, 1'b0, 1'b0, 1, 20'h100};
    vt[2] = '{1'b0, 4'b0010, 1'b0, 1'b0, 4'b0010, 1'b1, 1'b0, 1'b0, 2, 20'h101};
    vt[3] = '{1'b0, 4'b0110, 1'b0, 1'b0, 4'b0100, 1'b1, 1'b0, 1'b0, 3, 20'h102};
    vt[4] = '{1'b0, 4'b0011, 1'b0, 1'b0, 4'b0001, 1'b1, 1'b0, 1'b0, 4, 20'h100};
    vt[5] = '{1'b0, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4, 20'h100};
    vt[6] = '{1'b0, 4'b1000, 1'b1, 1'b0, 4'b1000, 1'b1, 1'b0, 1'b0, 5, 20'h103};
    vt[7] = '{1'b1, 4'b1111, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 0, 20'h000};
    for (int v = 0; v < 8; v++) begin
      rst = vt[v].rst; req = vt[v].req; cons_req = vt[v].cr; cons_ack = vt[v].ca;
      tick();
      check("vec_gnt", gnt, vt[v].gnt);
      check("vec_wr", trk_write, vt[v].wr);
      check("vec_rd", trk_read, vt[v].rd);
      check("vec_win", win_valid, vt[v].win);
      check("vec_count", count, vt[v].cnt);
      check("vec_din", trk_din, vt[v].din);
      check("vec_empty", empty, vt[v].cnt == 0);
      $display("vec %0d: req=%b gnt=%b count=%0d din=%0h", v, req, gnt, count, trk_din);
    end

    // Single requester streaming addresses 1..256 back to back.
    do_reset();
    req = 4'b0001;
    for (int i = 1; i <= 256; i++) begin
      req_addr[0 +: ADDR_W] = ADDR_W'(i);
      tick();
      check("seq_gnt0", gnt, 4'b0001);
      check("seq_din", trk_din, i);
    end
    req = '0;
    tick();
    check("seq_count256", count, 256);
    $display("seq: 256 writes from requester 0, count=%0d", count);

    // All requesters held: strict rotation, one write per cycle.
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 16; i++) begin
      tick();
      check("rr_gnt", gnt, 4'b0001 << (i % 4));
      check("rr_wr", trk_write, 1'b1);
    end
    req = '0;
    $display("rr: 16 rotating grants, count=%0d", count);

    // Fill to DEPTH, then a held request must wait for a read.
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < DEPTH; i++) tick();
    req = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("full_gnt", gnt, 4'b0000);
      check("full_flag", full, 1'b1);
      check("full_count", count, DEPTH);
    end
    cons_req = 1'b1;
    tick();
    check("full_rd", trk_read, 1'b1);
    check("full_rd_count", count, DEPTH - RD_STEP);
    cons_req = 1'b0;
    tick();
    check("full_hold_gnt", gnt, 4'b0000);
    cons_ack = 1'b1;
    tick();
    cons_ack = 1'b0;
    tick();
    check("full_late_gnt", gnt, 4'b0100);
    check("full_late_count", count, DEPTH - RD_STEP + 1);
    req = '0;
    $display("full: held off at %0d, granted after read, count=%0d", DEPTH, count);

    // Window threshold: seven entries hold off the read, the eighth releases it.
    do_reset();
    req = 4'b0001;
    for (int i = 0; i < 7; i++) tick();
    req = '0; cons_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("win7_rd", trk_read, 1'b0);
      check("win7_count", count, 7);
    end
    req = 4'b0001;
    tick();
    check("win8_count", count, 8);
    check("win8_rd", trk_read, 1'b0);
    req = '0;
    tick();
    check("win8_read", trk_read, 1'b1);
    check("win8_after", count, 6);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("win_hold", win_valid, 1'b1);
      check("win_single_rd", trk_read, 1'b0);
    end
    cons_ack = 1'b1;
    tick();
    check("win_drop", win_valid, 1'b0);
    cons_ack = 1'b0; cons_req = 1'b0;
    tick();
    $display("window: read at 8, count=%0d", count);

    // Read beats write; reset during WR aborts cleanly.
    do_reset();
    req = 4'b0001;
    for (int i = 0; i < 8; i++) tick();
    cons_req = 1'b1;
    tick();
    check("prio_rd", trk_read, 1'b1);
    check("prio_no_gnt", gnt, 4'b0000);
    cons_req = 1'b0;
    tick();
    check("hold_no_wr", trk_write, 1'b0);
    cons_ack = 1'b1;
    tick();
    cons_ack = 1'b0;
    tick();
    check("prio_wr_after", trk_write, 1'b1);
    check("prio_count", count, 7);
    rst = 1'b1;
    tick();
    check("rst_wr", trk_write, 1'b0);
    check("rst_count", count, 0);
    rst = 1'b0; req = '0;
    tick();
    check("rst_idle", trk_write, 1'b0);
    $display("prio/reset: read first, reset mid-write, count=%0d", count);

    // Random traffic; requesters keep req/address stable until granted.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      rst      = ($urandom_range(0, 999) == 0);
      cons_req = ($urandom_range(0, 3) == 0);
      cons_ack = ($urandom_range(0, 2) == 0);
      tick();
      for (int k = 0; k < NREQ; k++) begin
        if (m_gnt[k] || !req[k]) begin
          req[k] = ($urandom_range(0, 2) != 0);
          req_addr[k*ADDR_W +: ADDR_W] = ADDR_W'($urandom);
        end
      end
    end
    $display("random: 4000 cycles, final count=%0d", count);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tracker_ctrl.md
TRACKER_CTRL -- requirements
Module: tracker_ctrl

Interface
REQ-001 Parameter ADDR_W, default 20, width of the address entries passed to the input tracker.
REQ-002 Parameter NREQ, default 4, number of address requesters.
REQ-003 Parameter DEPTH, default 512, tracker entry capacity.
REQ-004 Parameter WIN, default 8, minimum occupancy before a read may issue (d0..d7 window).
REQ-005 Parameter RD_STEP, default 2, entries consumed per trk_read pulse.
REQ-006 Clocking: one clock, clk; reset rst is synchronous and active-high.
REQ-007 Port list (name  direction  width  meaning):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req  in  NREQ  per-requester write request, level
- req_addr  in  NREQ*ADDR_W  packed requester addresses; requester k uses slice k
- gnt  out  NREQ  one-hot write grant, 1-cycle pulse
- cons_req  in  1  consumer wants a window, level
- cons_ack  in  1  consumer has taken the window
- win_valid  out  1  tracker window outputs valid for the consumer
- trk_din  out  ADDR_W  address to tracker din
- trk_write  out  1  tracker write strobe
- trk_read  out  1  tracker read strobe
- count  out  10  current tracker occupancy
- full  out  1  count == DEPTH
- empty  out  1  count == 0

Function
REQ-008 All outputs shall be registered; each output shall reflect the FSM state entered at the preceding clock edge.
REQ-009 The FSM shall have four states: IDLE, WR, RD, HOLD.
REQ-010 Eligibility: a read is eligible when cons_req=1 and count>=WIN; a write is eligible when any req bit=1 and count<DEPTH.
REQ-011 IDLE and WR transitions: read eligible -> RD; else write eligible -> WR; else -> IDLE.
REQ-012 RD shall assert trk_read for exactly one cycle, subtract RD_STEP from count, then go to HOLD.
REQ-013 HOLD shall hold win_valid=1 until cons_ack=1 is sampled; it then returns to IDLE with win_valid=0 next cycle.
REQ-014 In HOLD, no trk_write and no gnt shall be issued.
REQ-015 In each WR cycle:
- trk_write=1;
- gnt shall be one-hot for the selected requester k;
- trk_din = req_addr slice k;
- count shall increment by 1.
REQ-016 WR cycles may be back-to-back, giving one write per cycle while writes remain eligible and no read is eligible.
REQ-017 Selection shall be round-robin: search starts at pointer rr, and rr becomes k+1 mod NREQ after a grant to k.
REQ-018 A requester shall hold req and its address stable until its gnt pulse, and shall drop or refresh req in the cycle after gnt.
REQ-019 When read and write are both eligible at a decision point, the read shall win.
REQ-020 Full: with count==DEPTH, no gnt and no trk_write shall occur; req is ignored without loss, and count shall never exceed DEPTH.
REQ-021 Below WIN: with count<WIN, cons_req shall be held off and trk_read shall stay 0; count shall never underflow.
REQ-022 full and empty shall be derived from the registered count in the same cycle as count.
REQ-023 trk_write and trk_read shall never be asserted in the same cycle.

Reset
REQ-024 When rst=1 at a clock edge, the block shall enter IDLE with count=0, rr=0, gnt=0, trk_write=0, trk_read=0, trk_din=0, win_valid=0, full=0, empty=1.
REQ-025 Reset taken mid-WR or mid-HOLD shall abort the operation with no further strobes.

Verification
REQ-026 The bench shall cover these directed scenarios:
- rst=1 for one cycle -> all outputs equal their REQ-024 values; empty=1; count=0.
- req[0]=1 with addresses 1..256 presented sequentially -> 256 consecutive gnt[0] pulses; trk_din = 1..256 in order; count=256.
- req=4'b1111 held continuously -> grant order 0,1,2,3,0,1,...; one trk_write per cycle.
- 512 writes, then req[2] held -> full=1, count=512; gnt stays 0 until a read frees entries.
- count=7 with cons_req=1 -> no trk_read; one more write makes count=8 -> single trk_read pulse; win_valid=1 until cons_ack; count=6.
- Simultaneous eligible cons_req and req -> RD precedes WR; rst asserted during WR -> next cycle IDLE with count=0.
